// File: rtl/snn_mem_pkg.sv
// Shared constants and types for the SNN banked memory controller.
// Bank map defaults: cfg, forward, target, weights, gradients, neuron state.
package snn_mem_pkg;

  localparam int DEF_NUM_BANKS = 6;
  localparam int DEF_SEL_W     = 4;
  localparam int DEF_RD_LAT    = 2;

  // Bank 0 sits in the least significant field of each packed constant.
  localparam logic [DEF_NUM_BANKS*DEF_SEL_W-1:0] DEF_BANK_LO =
    {4'hE, 4'h9, 4'h4, 4'h3, 4'h1, 4'h0};
  localparam logic [DEF_NUM_BANKS*DEF_SEL_W-1:0] DEF_BANK_HI =
    {4'hE, 4'hC, 4'h7, 4'h3, 4'h2, 4'h0};
  localparam logic [DEF_NUM_BANKS*5-1:0] DEF_BANK_AW =
    {5'd8, 5'd12, 5'd12, 5'd10, 5'd11, 5'd10};

  localparam int BANK_CFG   = 0;
  localparam int BANK_FWD   = 1;
  localparam int BANK_TGT   = 2;
  localparam int BANK_WGT   = 3;
  localparam int BANK_GRAD  = 4;
  localparam int BANK_STATE = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/snn_banked_mem_ctrl_if.sv
// Request/response and bank-clear signal bundle for snn_banked_mem_ctrl.
interface snn_banked_mem_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  clr_start;
  logic [2:0]            clr_bank;
  logic                  clr_busy;
  logic                  clr_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, clr_start, clr_bank,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, clr_busy, clr_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, clr_start, clr_bank,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, clr_busy, clr_done
  );
endinterface

// File: rtl/snn_bram_bank.sv
// Single-port write-first byte-enable RAM with optional output register.
module snn_bram_bank #(
  parameter int AW      = 10,
  parameter int DATA_W  = 32,
  parameter bit OUT_REG = 1'b1
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);
  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**AW];
  logic [DATA_W-1:0] dout_reg;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (we && be[b]) begin
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
          dout_reg[b*8 +: 8]  <= wdata[b*8 +: 8];
        end else begin
          dout_reg[b*8 +: 8]  <= mem[addr][b*8 +: 8];
        end
      end
    end
  end

  generate
    if (OUT_REG) begin : g_oreg
      logic [DATA_W-1:0] out_reg;
      always_ff @(posedge clk) out_reg <= dout_reg;
      assign rdata = out_reg;
    end else begin : g_noreg
      assign rdata = dout_reg;
    end
  endgenerate
endmodule

// File: rtl/snn_banked_mem_ctrl.sv
// Banked on-chip memory controller: address decode, fixed-latency response
// pipeline, byte-enabled writes and a hardware bank-clear engine.
module snn_banked_mem_ctrl
  import snn_mem_pkg::*;
#(
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = DEF_SEL_W,
  parameter logic [NUM_BANKS*SEL_W-1:0] BANK_LO = DEF_BANK_LO,
  parameter logic [NUM_BANKS*SEL_W-1:0] BANK_HI = DEF_BANK_HI,
  parameter logic [NUM_BANKS*5-1:0]     BANK_AW = DEF_BANK_AW,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input logic clk,
  input logic rst,
  snn_banked_mem_ctrl_if.slave bus
);
  localparam int BE_W   = DATA_W / 8;
  localparam int WORD_W = ADDR_W - 2;

  state_t              state_reg, state_next;
  logic [2:0]          clr_bank_reg, clr_bank_next;
  logic [WORD_W-1:0]   clr_cnt_reg, clr_cnt_next;
  logic                clr_done_reg, clr_done_next;

  logic [WORD_W-1:0]   clr_last [8];
  logic [DATA_W-1:0]   bank_rdata [8];
  logic [NUM_BANKS-1:0] hit;
  logic [SEL_W-1:0]    sel;
  logic [2:0]          dec_bank;
  logic                dec_err;
  logic                accept;
  logic                unused_addr;

  logic [RD_LAT-1:0]   vld_pipe;
  logic [RD_LAT-1:0]   err_pipe;
  logic [RD_LAT-1:0]   wr_pipe;
  logic [2:0]          idx_pipe [RD_LAT];

  assign sel         = bus.req_addr[ADDR_W-1 -: SEL_W];
  assign unused_addr = ^bus.req_addr[1:0];

  assign bus.req_ready = !rst && (state_reg == ST_IDLE) && !bus.clr_start;
  assign accept        = bus.req_valid && bus.req_ready;

  // Lowest-index hit wins when regions overlap.
  always_comb begin
    dec_bank = '0;
    dec_err  = 1'b1;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        dec_bank = 3'(i);
        dec_err  = 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bank
      if (gi < NUM_BANKS) begin : g_used
        localparam int AW = int'(BANK_AW[gi*5 +: 5]);
        localparam logic [SEL_W-1:0]  LO   = BANK_LO[gi*SEL_W +: SEL_W];
        localparam logic [SEL_W-1:0]  SPAN = BANK_HI[gi*SEL_W +: SEL_W] - LO;
        localparam logic [WORD_W-1:0] BASE = WORD_W'(LO) << (WORD_W - SEL_W);

        logic [SEL_W-1:0]  sel_off;
        logic [WORD_W-1:0] word_off;
        logic              clearing;
        logic              en;
        logic              we;
        logic [AW-1:0]     addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
        logic              unused_off;

        // Unsigned wrap turns the range test into a single compare.
        assign sel_off    = sel - LO;
        assign hit[gi]    = (sel_off <= SPAN);
        assign word_off   = bus.req_addr[ADDR_W-1:2] - BASE;
        assign unused_off = ^word_off;

        assign clearing = (state_reg == ST_CLEAR) && (clr_bank_reg == 3'(gi));
        assign en       = clearing || (accept && !dec_err && (dec_bank == 3'(gi)));
        assign we       = clearing || bus.req_we;
        assign addr     = clearing ? clr_cnt_reg[AW-1:0] : word_off[AW-1:0];
        assign be       = clearing ? {BE_W{1'b1}} : bus.req_be;
        assign wdata    = clearing ? '0 : bus.req_wdata;

        assign clr_last[gi] = {WORD_W{1'b1}} >> (WORD_W - AW);

        snn_bram_bank #(
          .AW      (AW),
          .DATA_W  (DATA_W),
          .OUT_REG (RD_LAT == 2)
        ) u_bank (
          .clk   (clk),
          .en    (en),
          .we    (we),
          .be    (be),
          .addr  (addr),
          .wdata (wdata),
          .rdata (bank_rdata[gi])
        );
      end else begin : g_absent
        assign clr_last[gi]   = '0;
        assign bank_rdata[gi] = '0;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      clr_bank_reg <= '0;
      clr_cnt_reg  <= '0;
      clr_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_bank_reg <= clr_bank_next;
      clr_cnt_reg  <= clr_cnt_next;
      clr_done_reg <= clr_done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_bank_next = clr_bank_reg;
    clr_cnt_next  = clr_cnt_reg;
    clr_done_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.clr_start) begin
          if ({1'b0, bus.clr_bank} < 4'(NUM_BANKS)) begin
            state_next    = ST_CLEAR;
            clr_bank_next = bus.clr_bank;
            clr_cnt_next  = '0;
          end else begin
            // Nonexistent bank: acknowledge without touching memory.
            clr_done_next = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        clr_cnt_next = clr_cnt_reg + WORD_W'(1);
        if (clr_cnt_reg == clr_last[clr_bank_reg]) begin
          state_next    = ST_IDLE;
          clr_done_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Control side-band travels alongside the RAM data, RD_LAT stages deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      wr_pipe  <= '0;
      for (int i = 0; i < RD_LAT; i++) idx_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= accept;
      err_pipe[0] <= dec_err;
      wr_pipe[0]  <= bus.req_we;
      idx_pipe[0] <= dec_bank;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        err_pipe[i] <= err_pipe[i-1];
        wr_pipe[i]  <= wr_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  assign bus.rsp_valid = vld_pipe[RD_LAT-1];
  assign bus.rsp_err   = vld_pipe[RD_LAT-1] && err_pipe[RD_LAT-1];
  assign bus.rsp_rdata = (vld_pipe[RD_LAT-1] && !err_pipe[RD_LAT-1] && !wr_pipe[RD_LAT-1])
                         ? bank_rdata[idx_pipe[RD_LAT-1]] : '0;
  assign bus.clr_busy  = (state_reg == ST_CLEAR);
  assign bus.clr_done  = clr_done_reg;
endmodule

// File: tb/tb_snn_banked_mem_ctrl.sv
// Scoreboard bench for snn_banked_mem_ctrl: directed requests push expected
// responses; a negedge monitor pops and checks data, error flag and latency.
module tb_snn_banked_mem_ctrl;
  import snn_mem_pkg::*;

  localparam int LAT = DEF_RD_LAT;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snn_banked_mem_ctrl_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  snn_banked_mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid with rdata 0x%h err %0b, expected none",
                 bus.rsp_rdata, bus.rsp_err);
      end else begin
        e = sb.pop_front();
        $display("rsp %-14s rdata=0x%h err=%0b lat=%0d", e.tag, bus.rsp_rdata, bus.rsp_err, cyc - e.cyc);
        chk({e.tag, "_rdata"}, bus.rsp_rdata, e.rdata);
        chk({e.tag, "_err"}, 32'(bus.rsp_err), 32'(e.err));
        chk({e.tag, "_lat"}, 32'(cyc - e.cyc), 32'(LAT));
      end
    end
  end

  task automatic send(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                      input string tag);
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_be    = be;
    for (int w = 0; w < 50 && bus.req_ready !== 1'b1; w++) begin
      @(posedge clk);
      #1;
    end
    if (bus.req_ready !== 1'b1) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_ready: got req_ready %b, expected 1 within 50 cycles", tag, bus.req_ready);
    end else begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.cyc   = cyc;
      e.tag   = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int busy_cnt, done_cnt, rdy_bad, done_at;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.clr_start = 1'b0;
    bus.clr_bank  = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    chk("rst_clr_busy",  32'(bus.clr_busy),  32'd0);
    chk("rst_clr_done",  32'(bus.clr_done),  32'd0);
    rst = 1'b0;
    #1;
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);

    // Basic write/read, byte enables with read-after-write, unmapped accesses.
    send(1'b1, 16'h4000, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, "wr_4000");
    send(1'b1, 16'h4004, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "wr_4004");
    send(1'b0, 16'h4004, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, "rd_4004");
    send(1'b1, 16'hE010, 32'h11223344, 4'hF, 32'h0, 1'b0, "wr_e010");
    send(1'b1, 16'hE010, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0, "wr_e010_be5");
    send(1'b0, 16'hE010, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, "rd_e010");
    send(1'b0, 16'h8000, 32'h0,        4'h0, 32'h0, 1'b1, "rd_8000");
    send(1'b0, 16'hF000, 32'h0,        4'h0, 32'h0, 1'b1, "rd_f000");
    send(1'b1, 16'h8000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "wr_8000");
    send(1'b0, 16'h4000, 32'h0,        4'h0, 32'h0BADF00D, 1'b0, "rd_4000");
    send(1'b1, 16'h1000, 32'h1,        4'hF, 32'h0, 1'b0, "wr_1000");
    send(1'b1, 16'h2000, 32'h2,        4'hF, 32'h0, 1'b0, "wr_2000");
    send(1'b0, 16'h1000, 32'h0,        4'h0, 32'h1, 1'b0, "rd_1000");
    send(1'b0, 16'h2000, 32'h0,        4'h0, 32'h2, 1'b0, "rd_2000");

    // Gradient fill, then a clear that races a pending request.
    send(1'b1, 16'h9000, 32'h12345678, 4'hF, 32'h0, 1'b0, "wr_9000");
    send(1'b1, 16'hCFFC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, "wr_cffc");
    send(1'b1, 16'hA000, 32'h55AA55AA, 4'hF, 32'h0, 1'b0, "wr_a000");
    send(1'b0, 16'h9000, 32'h0,        4'h0, 32'h12345678, 1'b0, "rd_9000_pre");
    send(1'b0, 16'h4004, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, "rd_4004_drain");
    bus.req_we    = 1'b0;
    bus.req_addr  = 16'h4004;
    bus.clr_start = 1'b1;
    bus.clr_bank  = 3'd4;
    #1;
    chk("clr_start_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.clr_start = 1'b0;
    bus.req_valid = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    rdy_bad  = 0;
    done_at  = -1;
    for (int i = 0; i < 4200; i++) begin
      if (bus.clr_busy === 1'b1) busy_cnt++;
      if (bus.clr_done === 1'b1) begin
        done_cnt++;
        done_at = i;
      end
      if (bus.clr_busy === 1'b1 && bus.req_ready !== 1'b0) rdy_bad++;
      @(posedge clk);
      #1;
    end
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd4096);
    chk("clr_done_pulses", 32'(done_cnt), 32'd1);
    chk("clr_done_at",     32'(done_at),  32'd4096);
    chk("clr_ready_high",  32'(rdy_bad),  32'd0);
    send(1'b0, 16'h9000, 32'h0, 4'h0, 32'h0, 1'b0, "rd_9000_clr");
    send(1'b0, 16'hCFFC, 32'h0, 4'h0, 32'h0, 1'b0, "rd_cffc_clr");
    send(1'b0, 16'hA000, 32'h0, 4'h0, 32'h0, 1'b0, "rd_a000_clr");
    send(1'b0, 16'h4004, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "rd_4004_keep");
    send(1'b0, 16'h4000, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, "rd_4000_keep");
    idle();
    drain();

    // Clear of a nonexistent bank acknowledges next cycle without going busy.
    bus.clr_start = 1'b1;
    bus.clr_bank  = 3'd7;
    @(posedge clk);
    #1;
    bus.clr_start = 1'b0;
    chk("badclr_done", 32'(bus.clr_done), 32'd1);
    chk("badclr_busy", 32'(bus.clr_busy), 32'd0);
    @(posedge clk);
    #1;
    chk("badclr_done_off", 32'(bus.clr_done), 32'd0);

    // Eight back-to-back reads.
    send(1'b0, 16'h4004, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "b2b_0");
    send(1'b0, 16'hE010, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, "b2b_1");
    send(1'b0, 16'h1000, 32'h0, 4'h0, 32'h1,        1'b0, "b2b_2");
    send(1'b0, 16'h2000, 32'h0, 4'h0, 32'h2,        1'b0, "b2b_3");
    send(1'b0, 16'h9000, 32'h0, 4'h0, 32'h0,        1'b0, "b2b_4");
    send(1'b0, 16'h8000, 32'h0, 4'h0, 32'h0,        1'b1, "b2b_5");
    send(1'b0, 16'h4000, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, "b2b_6");
    send(1'b0, 16'h4004, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "b2b_7");
    idle();
    drain();

    // Reset in the middle of a clear.
    bus.clr_start = 1'b1;
    bus.clr_bank  = 3'd0;
    @(posedge clk);
    #1;
    bus.clr_start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("midclr_busy", 32'(bus.clr_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstclr_busy",      32'(bus.clr_busy),  32'd0);
    chk("rstclr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstclr_ready",     32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("postrst_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("postrst_busy",      32'(bus.clr_busy),  32'd0);
    chk("postrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("postrst_done",      32'(bus.clr_done),  32'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
